// File: rtl/nonconsecutive_seq_gen.sv
// nonconsecutive_seq_gen
//   Pattern generator: on a request emits N_A A symbols, consecutive A's
//   separated by B_LEN B symbols, then one C, then returns to IDLE.
//   Symbol encoding (zero-extended to SYM_W): IDLE=0, A=1, B=2, C=3.
//   An embedded monitor watches o_sequence and counts legal completions.
// Ports
//   i_clk        clock, posedge
//   i_rstn       synchronous active-low reset
//   i_req        start request, only sampled while o_ready=1
//   o_ready      state is IDLE
//   o_running    state is A, B or C
//   o_sequence   current state symbol
//   o_done       high for the single C cycle
//   o_match_cnt  saturating count of legal completions seen by the monitor
//   o_err        sticky monitor violation flag
module nonconsecutive_seq_gen #(
  parameter int SYM_W = 2,
  parameter int N_A   = 2,
  parameter int B_LEN = 3,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_req,
  output logic             o_ready,
  output logic             o_running,
  output logic [SYM_W-1:0] o_sequence,
  output logic             o_done,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_err
);

  if (SYM_W < 2 || N_A < 1 || N_A > 15 || B_LEN < 1 || B_LEN > 15 || CNT_W < 1) begin : g_bad_param
    $error("nonconsecutive_seq_gen: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2,
    S_C    = 2'd3
  } state_e;

  localparam logic [3:0]       A_LAST    = 4'(N_A - 1);
  localparam logic [3:0]       B_LAST    = 4'(B_LEN - 1);
  localparam logic [3:0]       N_A_4     = 4'(N_A);
  localparam logic [SYM_W-1:0] SYM_IDLE  = SYM_W'(0);
  localparam logic [SYM_W-1:0] SYM_A     = SYM_W'(1);
  localparam logic [SYM_W-1:0] SYM_C     = SYM_W'(3);
  localparam logic [CNT_W-1:0] MATCH_MAX = {CNT_W{1'b1}};

  state_e     state_q, state_d;
  logic [3:0] a_cnt_q, a_cnt_d;
  logic [3:0] b_cnt_q, b_cnt_d;

  // Monitor state
  logic [3:0]       mon_cnt_q, mon_cnt_d;
  logic             prev_a_q, prev_a_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic             err_q, err_d;

  // ---------------- generator FSM ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    case (state_q)
      S_IDLE: if (i_req) state_d = S_A;
      S_A: begin
        if (a_cnt_q == A_LAST) begin
          state_d = S_C;
          a_cnt_d = '0;
        end else begin
          state_d = S_B;
          a_cnt_d = a_cnt_q + 4'd1;
          b_cnt_d = '0;
        end
      end
      S_B: begin
        if (b_cnt_q == B_LAST) begin
          state_d = S_A;
          b_cnt_d = '0;
        end else begin
          b_cnt_d = b_cnt_q + 4'd1;
        end
      end
      S_C:     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_sequence = SYM_W'(state_q);
  assign o_ready    = (state_q == S_IDLE);
  assign o_running  = (state_q != S_IDLE);
  assign o_done     = (state_q == S_C);

  // ---------------- monitor ----------------
  // Decodes o_sequence only, so it checks the generator rather than sharing
  // its counters.
  logic is_a, is_c, is_idle;
  assign is_a    = (o_sequence == SYM_A);
  assign is_c    = (o_sequence == SYM_C);
  assign is_idle = (o_sequence == SYM_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      mon_cnt_q <= '0;
      prev_a_q  <= 1'b0;
      match_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      mon_cnt_q <= mon_cnt_d;
      prev_a_q  <= prev_a_d;
      match_q   <= match_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    mon_cnt_d = mon_cnt_q;
    prev_a_d  = is_a;
    match_d   = match_q;
    err_d     = err_q;
    if (is_a) begin
      if (prev_a_q) err_d = 1'b1;
      if (mon_cnt_q != 4'hF) mon_cnt_d = mon_cnt_q + 4'd1;
    end else if (is_c) begin
      mon_cnt_d = '0;
      if (mon_cnt_q == N_A_4) begin
        if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (is_idle) begin
      mon_cnt_d = '0;
    end
  end

  assign o_match_cnt = match_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_nonconsecutive_seq_gen.sv
// Directed bench for nonconsecutive_seq_gen. Four instances cover the
// parameter sets of interest (defaults, N_A=3/B_LEN=1, N_A=1, CNT_W=2).
// Expected symbol streams are built from the sequence rule into a queue when
// a request is driven and popped one per cycle against the DUT.
module tb_nonconsecutive_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: defaults, 1: N_A=3 B_LEN=1, 2: N_A=1, 3: CNT_W=2
  logic       rstn0, rstn1, rstn2, rstn3;
  logic       req0, req1, req2, req3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       run0, run1, run2, run3;
  logic       dn0, dn1, dn2, dn3;
  logic       err0, err1, err2, err3;
  logic [1:0] seq0, seq1, seq2, seq3;
  logic [3:0] mc0, mc1, mc2;
  logic [1:0] mc3;

  nonconsecutive_seq_gen u_def (
    .i_clk(clk), .i_rstn(rstn0), .i_req(req0), .o_ready(rdy0), .o_running(run0),
    .o_sequence(seq0), .o_done(dn0), .o_match_cnt(mc0), .o_err(err0));

  nonconsecutive_seq_gen #(.N_A(3), .B_LEN(1)) u_n3 (
    .i_clk(clk), .i_rstn(rstn1), .i_req(req1), .o_ready(rdy1), .o_running(run1),
    .o_sequence(seq1), .o_done(dn1), .o_match_cnt(mc1), .o_err(err1));

  nonconsecutive_seq_gen #(.N_A(1)) u_n1 (
    .i_clk(clk), .i_rstn(rstn2), .i_req(req2), .o_ready(rdy2), .o_running(run2),
    .o_sequence(seq2), .o_done(dn2), .o_match_cnt(mc2), .o_err(err2));

  nonconsecutive_seq_gen #(.CNT_W(2)) u_c2 (
    .i_clk(clk), .i_rstn(rstn3), .i_req(req3), .o_ready(rdy3), .o_running(run3),
    .o_sequence(seq3), .o_done(dn3), .o_match_cnt(mc3), .o_err(err3));

  typedef struct {
    int seq;
    int rdy;
    int run;
    int done;
    int mcnt;
    int err;
  } obs_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      0:       o = '{int'(seq0), int'(rdy0), int'(run0), int'(dn0), int'(mc0), int'(err0)};
      1:       o = '{int'(seq1), int'(rdy1), int'(run1), int'(dn1), int'(mc1), int'(err1)};
      2:       o = '{int'(seq2), int'(rdy2), int'(run2), int'(dn2), int'(mc2), int'(err2)};
      default: o = '{int'(seq3), int'(rdy3), int'(run3), int'(dn3), int'(mc3), int'(err3)};
    endcase
    return o;
  endfunction

  task automatic set_req(input int d, input logic v);
    case (d)
      0: req0 = v;
      1: req1 = v;
      2: req2 = v;
      default: req3 = v;
    endcase
  endtask

  task automatic set_rstn(input int d, input logic v);
    case (d)
      0: rstn0 = v;
      1: rstn1 = v;
      2: rstn2 = v;
      default: rstn3 = v;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks every decoded output against one expected symbol.
  task automatic chk_sym(input string tag, input int d, input int sym);
    obs_t o;
    o = get_obs(d);
    chk({tag, ".seq"},  o.seq,  sym);
    chk({tag, ".rdy"},  o.rdy,  int'(sym == 0));
    chk({tag, ".run"},  o.run,  int'(sym != 0));
    chk({tag, ".done"}, o.done, int'(sym == 3));
    chk({tag, ".err"},  o.err,  0);
  endtask

  task automatic push_seq(input int na, input int bl);
    exp_q.push_back(1);
    for (int i = 1; i < na; i++) begin
      for (int j = 0; j < bl; j++) exp_q.push_back(2);
      exp_q.push_back(1);
    end
    exp_q.push_back(3);
    exp_q.push_back(0);
  endtask

  // Issues one request (left high when hold=1) and checks the whole stream,
  // ending on the trailing IDLE cycle.
  task automatic run_seq(input string tag, input int d, input int na, input int bl,
                         input bit hold);
    int sym;
    push_seq(na, bl);
    set_req(d, 1'b1);
    tick();
    if (!hold) set_req(d, 1'b0);
    while (exp_q.size() > 0) begin
      sym = exp_q.pop_front();
      chk_sym(tag, d, sym);
      if (exp_q.size() > 0) tick();
    end
  endtask

  task automatic do_reset(input int d);
    set_rstn(d, 1'b0);
    tick();
    set_rstn(d, 1'b1);
  endtask

  initial begin
    req0 = 0; req1 = 0; req2 = 0; req3 = 0;
    rstn0 = 0; rstn1 = 0; rstn2 = 0; rstn3 = 0;
    tick();
    tick();
    rstn0 = 1; rstn1 = 1; rstn2 = 1; rstn3 = 1;

    // reset state of every instance
    for (int d = 0; d < 4; d++) begin
      chk_sym("reset", d, 0);
      chk("reset.mcnt", get_obs(d).mcnt, 0);
    end
    tick();
    tick();

    // 1: defaults -> 1,2,2,2,1,3,0
    run_seq("t1", 0, 2, 3, 0);
    chk("t1.mcnt", get_obs(0).mcnt, 1);

    // 2: N_A=3, B_LEN=1 -> 1,2,1,2,1,3,0
    run_seq("t2", 1, 3, 1, 0);
    chk("t2.mcnt", get_obs(1).mcnt, 1);

    // 3: N_A=1 -> 1,3,0 (o_ready low for two cycles)
    run_seq("t3", 2, 1, 3, 0);
    chk("t3.mcnt", get_obs(2).mcnt, 1);

    // 4: request held high, four back-to-back periods of 7
    do_reset(0);
    chk("t4.rst_mcnt", get_obs(0).mcnt, 0);
    for (int p = 0; p < 4; p++) begin
      run_seq("t4", 0, 2, 3, 1);
      chk("t4.mcnt", get_obs(0).mcnt, p + 1);
    end
    req0 = 0;
    tick();
    chk_sym("t4.drop", 0, 0);
    chk("t4.final_mcnt", get_obs(0).mcnt, 4);

    // 5: reset during the 2nd B cycle aborts with no completion
    req0 = 1;
    tick();
    req0 = 0;
    chk_sym("t5.a", 0, 1);
    tick();
    chk_sym("t5.b1", 0, 2);
    tick();
    chk_sym("t5.b2", 0, 2);
    do_reset(0);
    chk_sym("t5.abort", 0, 0);
    chk("t5.mcnt", get_obs(0).mcnt, 0);
    tick();
    chk_sym("t5.idle", 0, 0);
    run_seq("t5.full", 0, 2, 3, 0);
    chk("t5.after_mcnt", get_obs(0).mcnt, 1);

    // 6: CNT_W=2 saturates at 3
    for (int k = 1; k <= 5; k++) begin
      run_seq("t6", 3, 2, 3, 0);
      chk("t6.mcnt", get_obs(3).mcnt, (k < 3) ? k : 3);
    end

    // no instance may have flagged a violation
    for (int d = 0; d < 4; d++) chk("end.err", get_obs(d).err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
